// File: rtl/rx_byte_fifo_pkg.sv
// Shared UART constants: byte width and default FIFO depth exponent, used by
// both the receive and transmit paths.
package rx_byte_fifo_pkg;
    localparam int UART_BW = 8;
    localparam int FIFO_AW = 4;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module fifo_mem
    import rx_byte_fifo_pkg::*;
#(
    parameter int DW = UART_BW,
    parameter int AW = FIFO_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver. The receiver is
// never stalled; bytes arriving while full are dropped and flagged.
module rx_byte_fifo
    import rx_byte_fifo_pkg::*;
#(
    parameter int BW        = UART_BW,
    parameter int AW        = FIFO_AW,
    parameter int AFULL_LVL = (2**AW) - 2
) (
    input  logic          clk,
    input  logic          i_reset_n,
    input  logic          in_valid,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    output logic [BW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_afull,
    output logic          o_overflow,
    input  logic          i_clear_ovf
);
    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_C = AFULL_LVL[AW:0];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, drop;
    logic [BW-1:0] rd_data;

    always_comb begin
        pop      = ~empty_q & out_ready;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        push     = in_valid & (~full_q | pop);
        drop     = in_valid & ~push;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        afull_d = (count_d >= AFULL_C);
        // A new drop outranks a clear in the same cycle.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    fifo_mem #(
        .DW (BW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Head is masked while empty so out_data reads 0 out of reset.
    assign out_data   = empty_q ? '0 : rd_data;
    assign out_valid  = ~empty_q;
    assign o_count    = count_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_afull    = afull_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_rx_byte_fifo.sv
// Bench for rx_byte_fifo: directed scenarios plus random traffic, compared
// against a queue-based reference model.
module tb_rx_byte_fifo;
    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [4:0] o_count;
    logic       o_full, o_empty, o_afull, o_overflow;
    logic       i_clear_ovf = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;

    rx_byte_fifo dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_afull     (o_afull),
        .o_overflow  (o_overflow),
        .i_clear_ovf (i_clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        int n;
        n = model_q.size();
        check("count", 32'(o_count), 32'(n));
        check("empty", 32'(o_empty), 32'(n == 0));
        check("full", 32'(o_full), 32'(n == 16));
        check("afull", 32'(o_afull), 32'(n >= 14));
        check("out_valid", 32'(out_valid), 32'(n != 0));
        check("overflow", 32'(o_overflow), 32'(model_ovf));
        if (n != 0) check("out_data", 32'(out_data), 32'(model_q[0]));
    endtask

    // One clock cycle: drive at negedge, advance the model, check after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        bit pushed;
        @(negedge clk);
        in_valid    = v;
        in_data     = d;
        out_ready   = rdy;
        i_clear_ovf = clr;
        if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
        pushed = 1'b0;
        if (v && model_q.size() < 16) begin
            model_q.push_back(d);
            pushed = 1'b1;
        end
        if (v && !pushed) model_ovf = 1'b1;
        else if (clr)     model_ovf = 1'b0;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        i_clear_ovf = 1'b0;
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(o_count), 32'd0);
        check({tag, "_empty"}, 32'(o_empty), 32'd1);
        check({tag, "_full"}, 32'(o_full), 32'd0);
        check({tag, "_afull"}, 32'(o_afull), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ovf"}, 32'(o_overflow), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
    endtask

    task automatic drain();
        while (model_q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #2 i_reset_n = 1'b1;

        // Single byte, held, then popped.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("a5_data", 32'(out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("a5_hold", 32'(out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("a5_empty", 32'(o_empty), 32'd1);

        // Fill, overflow, ordered drain.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(o_full), 32'd1);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_set", 32'(o_overflow), 32'd1);
        check("ovf_count", 32'(o_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("drain_order", 32'(out_data), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Push and pop together while full.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        check("pp_count", 32'(o_count), 32'd16);
        check("pp_ovf", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("pp_last", 32'(out_data), 32'hEE);
        drain();

        // Clear racing a drop: the drop wins.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b1);
        check("clr_race", 32'(o_overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_alone", 32'(o_overflow), 32'd0);
        drain();

        // Slow receiver with continuous pop across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'hC0 ^ i), 1'b1, 1'b0);
            check("slow_data", 32'(out_data), 32'(8'hC0 ^ i));
            for (int k = 0; k < 867; k++) begin
                step(1'b0, 8'h00, 1'b1, 1'b0);
                if (k < 2) check("slow_cnt_le1", 32'(o_count <= 5'd1), 32'd1);
            end
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 5));
        end
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle at count 7.
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(o_count), 32'd7);
        @(posedge clk);
        #3 i_reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        model_q.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #2 i_reset_n = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        check("post_rst_first", 32'(out_data), 32'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 The block SHALL have a parameter BW, default 8, giving the byte width carried per entry.
REQ-002 The block SHALL have a parameter AW, default 4, giving log2 of the depth; DEPTH = 2**AW = 16 entries.
REQ-003 The block SHALL have a parameter AFULL_LVL, default DEPTH-2, giving the almost-full threshold.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  one-cycle strobe from the UART receiver marking a received byte.
REQ-007 in_data  input  BW  received byte, sampled only when in_valid=1.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_data  output  BW  head entry, valid while out_valid=1.
REQ-010 out_ready  input  1  consumer accepts the head entry when out_valid and out_ready are both 1.
REQ-011 o_count  output  AW+1  current occupancy, 0..DEPTH.
REQ-012 o_full / o_empty / o_afull  output  1 each  occupancy==DEPTH / occupancy==0 / occupancy>=AFULL_LVL.
REQ-013 o_overflow  output  1  sticky flag set when a byte is dropped.
REQ-014 i_clear_ovf  input  1  synchronous clear of o_overflow.

Function
REQ-015 in_valid is a pulse with no back-pressure; the block SHALL never stall the upstream receiver.
REQ-016 A push SHALL occur when in_valid=1 and (o_full=0, or a pop occurs in the same cycle).
REQ-017 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-018 in_valid=1 while full with no simultaneous pop SHALL drop the byte, leave the contents unchanged, and set o_overflow on the next edge.
REQ-019 Write and read pointers SHALL be AW bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-020 o_count SHALL change by +1 on push only, by -1 on pop only, and SHALL be unchanged on push+pop.
REQ-021 Output is first-word-fall-through: a byte pushed into an empty FIFO at edge N SHALL show out_valid=1 with that out_data immediately after edge N, i.e. one cycle latency.
REQ-022 Push and pop in the same cycle while empty SHALL be impossible, because out_valid=0; the push alone SHALL take effect.
REQ-023 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 All status outputs SHALL be registered and consistent with o_count in the same cycle.
REQ-025 If i_clear_ovf and a new drop occur in the same cycle, the set SHALL win and o_overflow SHALL stay 1.
REQ-026 Ordering SHALL be strictly FIFO; there SHALL be no duplication or reordering across pointer wrap.

Reset
REQ-027 Asserting i_reset_n=0 SHALL, at any time and including mid-operation, asynchronously force both pointers=0, o_count=0, out_valid=0, o_empty=1, o_full=0, o_afull=0, o_overflow=0.
REQ-028 out_data SHALL reset to 0; memory contents need not be cleared.
REQ-029 An in_valid arriving in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-030 The shared package SHALL hold the UART byte width (8) and the default FIFO AW constant, reused by the receiver and transmitter paths.
REQ-031 Storage SHALL be a separate sub-module, fifo_mem: a simple dual-port register array with one write port and one asynchronous read port, no reset.
REQ-032 Pointer, count and flag logic SHALL live in rx_byte_fifo.

Verification
REQ-033 Reset release, then a single push 0xA5 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5, o_count=1; then out_ready=1 for one cycle -> o_empty=1.
REQ-034 Push 16 bytes 0x00..0x0F -> o_full=1, o_afull=1 from count 14; a 17th push 0xFF -> o_overflow=1, o_count=16, and draining yields 0x00..0x0F in order.
REQ-035 Full FIFO with in_valid=1 and pop in the same cycle -> o_count stays 16, o_overflow stays 0, and the new byte is last out.
REQ-036 40 bytes pushed one per 868 cycles while popping continuously -> all 40 bytes delivered in order across pointer wrap, o_count never exceeds 1.
REQ-037 i_clear_ovf=1 in the same cycle as a drop -> o_overflow=1; a later i_clear_ovf alone -> o_overflow=0.
REQ-038 i_reset_n pulsed low mid-cycle at count 7 -> outputs reset immediately without waiting for a clock edge; the next push 0x3C is the first byte out.
